// File: rtl/dram_bank_seq_if.sv
// dram_bank_seq_if
// Bundles the request channel, the read response and the single-bank DRAM
// command bus used by dram_bank_seq.
//   slave  : the sequencer side (takes requests and drives the bank).
//   master : the environment side (issues requests and returns read data).
// Signals:
//   req_valid/req_ready/req_rw/req_row/req_col/req_wdata : request handshake
//   close_req                                            : precharge request
//   cmd/cmd_row/cmd_col/cmd_we/dram_data_out             : bank command bus
//   dram_data_in                                         : bank read data
//   rsp_valid/rsp_data                                   : read response
//   row_open/open_row                                    : open-page status
interface dram_bank_seq_if #(
    parameter int NUM_OF_ROWS = 128,
    parameter int NUM_OF_COLS = 8,
    parameter int DATA_WIDTH  = 1
);
    localparam int ROW_W = $clog2(NUM_OF_ROWS);
    localparam int COL_W = $clog2(NUM_OF_COLS);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [ROW_W-1:0]      req_row;
    logic [COL_W-1:0]      req_col;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  close_req;
    logic [1:0]            cmd;
    logic [ROW_W-1:0]      cmd_row;
    logic [COL_W-1:0]      cmd_col;
    logic                  cmd_we;
    logic [DATA_WIDTH-1:0] dram_data_out;
    logic [DATA_WIDTH-1:0] dram_data_in;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  row_open;
    logic [ROW_W-1:0]      open_row;

    modport slave (
        input  req_valid, req_rw, req_row, req_col, req_wdata, close_req,
               dram_data_in,
        output req_ready, cmd, cmd_row, cmd_col, cmd_we, dram_data_out,
               rsp_valid, rsp_data, row_open, open_row
    );

    modport master (
        output req_valid, req_rw, req_row, req_col, req_wdata, close_req,
               dram_data_in,
        input  req_ready, cmd, cmd_row, cmd_col, cmd_we, dram_data_out,
               rsp_valid, rsp_data, row_open, open_row
    );
endinterface

// File: rtl/dram_bank_seq.sv
// dram_bank_seq
// Open-page command sequencer for a single DRAM bank. Accepts one read or
// write request at a time, issues PRE/ACT/RD-WR with the configured
// PRE-to-ACT, ACT-to-access and read latency spacing, and returns read data
// as a one-cycle response strobe. The last activated row stays open until a
// row miss or an explicit close request.
// Ports:
//   clk   : clock, rising edge
//   rst_b : asynchronous active-low reset
//   bus   : dram_bank_seq_if.slave (request, response and bank command bus)
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | waiting for a request or a close request
// PRE      | precharge command on the bus
// WAIT_RP  | PRE-to-ACT spacing
// ACT      | activate command on the bus
// WAIT_RCD | ACT-to-access spacing
// ACCESS   | RD/WR command on the bus
// WAIT_CL  | read latency, data captured on the last cycle
// RESP     | read response strobe, new request may be accepted
module dram_bank_seq #(
    parameter int NUM_OF_ROWS = 128,
    parameter int NUM_OF_COLS = 8,
    parameter int DATA_WIDTH  = 1,
    parameter int T_RP        = 2,
    parameter int T_RCD       = 2,
    parameter int T_CL        = 2
) (
    input  logic            clk,
    input  logic            rst_b,
    dram_bank_seq_if.slave  bus
);
    localparam int ROW_W = $clog2(NUM_OF_ROWS);
    localparam int COL_W = $clog2(NUM_OF_COLS);
    localparam int MAX_T = (T_RP > T_RCD) ? ((T_RP > T_CL) ? T_RP : T_CL)
                                          : ((T_RCD > T_CL) ? T_RCD : T_CL);
    localparam int CNT_W = $clog2(MAX_T + 1);

    // The command state itself is the first cycle of each spacing window, so
    // the wait states only cover the remaining T-1 cycles (count T-2 down to 0).
    // WAIT_CL follows ACCESS and covers the full read latency.
    localparam logic [CNT_W-1:0] RP_LD  = (T_RP  > 1) ? CNT_W'(T_RP  - 2) : '0;
    localparam logic [CNT_W-1:0] RCD_LD = (T_RCD > 1) ? CNT_W'(T_RCD - 2) : '0;
    localparam logic [CNT_W-1:0] CL_LD  = CNT_W'(T_CL - 1);

    typedef enum logic [2:0] {
        IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, ACCESS, WAIT_CL, RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  rw_q, rw_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  closing_q;
    logic                  ready;
    logic                  take;

    assign ready         = (state_q == IDLE) || (state_q == RESP);
    assign take          = ready && bus.req_valid;
    assign bus.req_ready = ready;

    // Request fields as they will be after this edge; lets a hit in IDLE/RESP
    // drive the registered RD/WR outputs in the very next cycle.
    always_comb begin
        rw_d    = take ? bus.req_rw    : rw_q;
        row_d   = take ? bus.req_row   : row_q;
        col_d   = take ? bus.req_col   : col_q;
        wdata_d = take ? bus.req_wdata : wdata_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (bus.req_valid) begin
                    if (bus.row_open && (bus.open_row == bus.req_row))
                        state_d = ACCESS;
                    else if (bus.row_open)
                        state_d = PRE;
                    else
                        state_d = ACT;
                end else if (bus.close_req && bus.row_open) begin
                    state_d = PRE;
                end
            end
            PRE: begin
                if (T_RP > 1)
                    state_d = WAIT_RP;
                else
                    state_d = closing_q ? IDLE : ACT;
            end
            WAIT_RP: begin
                if (cnt_q == '0)
                    state_d = closing_q ? IDLE : ACT;
            end
            ACT:      state_d = (T_RCD > 1) ? WAIT_RCD : ACCESS;
            WAIT_RCD: if (cnt_q == '0) state_d = ACCESS;
            ACCESS:   state_d = rw_q ? IDLE : WAIT_CL;
            WAIT_CL:  if (cnt_q == '0) state_d = RESP;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            wdata_q   <= '0;
            closing_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                case (state_d)
                    WAIT_RP:  cnt_q <= RP_LD;
                    WAIT_RCD: cnt_q <= RCD_LD;
                    WAIT_CL:  cnt_q <= CL_LD;
                    default:  cnt_q <= '0;
                endcase
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            rw_q    <= rw_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wdata_q <= wdata_d;
            if (ready)
                closing_q <= !bus.req_valid && bus.close_req && bus.row_open;
        end
    end

    // Registered bus outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bus.cmd           <= 2'b00;
            bus.cmd_row       <= '0;
            bus.cmd_col       <= '0;
            bus.cmd_we        <= 1'b0;
            bus.dram_data_out <= '0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_data      <= '0;
            bus.row_open      <= 1'b0;
            bus.open_row      <= '0;
        end else begin
            bus.cmd           <= 2'b00;
            bus.cmd_row       <= '0;
            bus.cmd_col       <= '0;
            bus.cmd_we        <= 1'b0;
            bus.dram_data_out <= '0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_data      <= '0;
            case (state_d)
                PRE: bus.cmd <= 2'b11;
                ACT: begin
                    bus.cmd     <= 2'b01;
                    bus.cmd_row <= row_d;
                end
                ACCESS: begin
                    bus.cmd           <= 2'b10;
                    bus.cmd_col       <= col_d;
                    bus.cmd_we        <= rw_d;
                    bus.dram_data_out <= rw_d ? wdata_d : '0;
                end
                RESP: begin
                    // Only reached from the last WAIT_CL cycle: this is the capture.
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= bus.dram_data_in;
                end
                default: ;
            endcase
            if (state_q == PRE) begin
                bus.row_open <= 1'b0;
                bus.open_row <= '0;
            end else if (state_q == ACT) begin
                bus.row_open <= 1'b1;
                bus.open_row <= row_q;
            end
        end
    end
endmodule

// File: tb/tb_dram_bank_seq.sv
// tb_dram_bank_seq
// Directed bench for dram_bank_seq with T_RP=T_CL=T_RCD=2. Each scenario
// counts cycles from the handshake cycle (cycle 0); inputs are driven and
// outputs sampled 1 ns after the rising edge.
module tb_dram_bank_seq;
    logic clk;
    logic rst_b;
    int   vectors;
    int   miscompares;

    dram_bank_seq_if bus ();

    dram_bank_seq dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [6:0] row, input logic [2:0] col,
                         input logic wd);
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_row   = row;
        bus.req_col   = col;
        bus.req_wdata = wd;
    endtask

    task automatic idle_req;
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_row   = '0;
        bus.req_col   = '0;
        bus.req_wdata = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_b       = 1'b0;
        idle_req();
        bus.close_req    = 1'b0;
        bus.dram_data_in = 1'b0;
        #12;
        chk("rst_ready",    bus.req_ready,     1);
        chk("rst_cmd",      bus.cmd,           0);
        chk("rst_row_open", bus.row_open,      0);
        chk("rst_open_row", bus.open_row,      0);
        chk("rst_rsp",      bus.rsp_valid,     0);
        chk("rst_dout",     bus.dram_data_out, 0);
        rst_b = 1'b1;
        tick();

        // closed-bank read row5 col3
        issue(1'b0, 7'd5, 3'd3, 1'b0);
        chk("s1_ready_c0", bus.req_ready, 1);
        tick();
        idle_req();
        chk("s1_act_c1",      bus.cmd,      1);
        chk("s1_actrow_c1",   bus.cmd_row,  5);
        chk("s1_rowopen_c1",  bus.row_open, 0);
        tick();
        chk("s1_nop_c2",      bus.cmd,      0);
        chk("s1_rowopen_c2",  bus.row_open, 1);
        chk("s1_openrow_c2",  bus.open_row, 5);
        tick();
        chk("s1_rd_c3",       bus.cmd,      2);
        chk("s1_col_c3",      bus.cmd_col,  3);
        chk("s1_we_c3",       bus.cmd_we,   0);
        chk("s1_ready_c3",    bus.req_ready, 0);
        tick();
        chk("s1_nop_c4",      bus.cmd,      0);
        bus.dram_data_in = 1'b0;
        tick();
        chk("s1_norsp_c5",    bus.rsp_valid, 0);
        bus.dram_data_in = 1'b1;
        tick();
        bus.dram_data_in = 1'b0;
        chk("s1_rsp_c6",      bus.rsp_valid, 1);
        chk("s1_rdata_c6",    bus.rsp_data,  1);
        chk("s1_ready_c6",    bus.req_ready, 1);
        tick();
        chk("s1_rspoff_c7",   bus.rsp_valid, 0);

        // hit write row5 col1
        issue(1'b1, 7'd5, 3'd1, 1'b1);
        tick();
        idle_req();
        chk("s2_wr_c1",    bus.cmd,           2);
        chk("s2_col_c1",   bus.cmd_col,       1);
        chk("s2_we_c1",    bus.cmd_we,        1);
        chk("s2_dout_c1",  bus.dram_data_out, 1);
        chk("s2_ready_c1", bus.req_ready,     0);
        tick();
        chk("s2_ready_c2", bus.req_ready,     1);
        chk("s2_dout_c2",  bus.dram_data_out, 0);
        chk("s2_we_c2",    bus.cmd_we,        0);
        for (int i = 0; i < 3; i++) begin
            chk("s2_norsp", bus.rsp_valid, 0);
            chk("s2_nocmd", bus.cmd,       0);
            tick();
        end

        // req_valid and close_req together, hit read row5 col6
        issue(1'b0, 7'd5, 3'd6, 1'b0);
        bus.close_req = 1'b1;
        tick();
        idle_req();
        bus.close_req = 1'b0;
        chk("s5_rd_c1",  bus.cmd,     2);
        chk("s5_col_c1", bus.cmd_col, 6);
        tick();
        chk("s5_nop_c2", bus.cmd, 0);
        tick();
        chk("s5_nop_c3", bus.cmd, 0);
        bus.dram_data_in = 1'b1;
        tick();
        bus.dram_data_in = 1'b0;
        chk("s5_rsp_c4",     bus.rsp_valid, 1);
        chk("s5_rdata_c4",   bus.rsp_data,  1);
        chk("s5_rowopen_c4", bus.row_open,  1);
        tick();

        // close with row5 open
        bus.close_req = 1'b1;
        tick();
        bus.close_req = 1'b0;
        chk("s4_pre_c1",     bus.cmd,       3);
        chk("s4_ready_c1",   bus.req_ready, 0);
        tick();
        chk("s4_nop_c2",     bus.cmd,       0);
        chk("s4_rowopen_c2", bus.row_open,  0);
        chk("s4_ready_c2",   bus.req_ready, 0);
        tick();
        chk("s4_ready_c3",   bus.req_ready, 1);
        chk("s4_nop_c3",     bus.cmd,       0);

        // close with bank already closed
        bus.close_req = 1'b1;
        tick();
        bus.close_req = 1'b0;
        chk("s4b_nop_c1",   bus.cmd,       0);
        chk("s4b_ready_c1", bus.req_ready, 1);
        tick();
        chk("s4b_nop_c2",   bus.cmd,       0);

        // reset during WAIT_RCD
        issue(1'b0, 7'd5, 3'd0, 1'b0);
        tick();
        idle_req();
        chk("s6_act_c1", bus.cmd, 1);
        tick();
        rst_b = 1'b0;
        #1;
        chk("s6_rst_cmd",     bus.cmd,       0);
        chk("s6_rst_rowopen", bus.row_open,  0);
        chk("s6_rst_ready",   bus.req_ready, 1);
        tick();
        chk("s6_rst_cmd2",    bus.cmd,       0);
        rst_b = 1'b1;
        tick();
        chk("s6_post_cmd",    bus.cmd,       0);
        issue(1'b0, 7'd5, 3'd7, 1'b0);
        tick();
        idle_req();
        chk("s6_act2_c1",    bus.cmd,     1);
        chk("s6_actrow_c1",  bus.cmd_row, 5);
        tick();
        tick();
        chk("s6_rd_c3",      bus.cmd,     2);
        chk("s6_col_c3",     bus.cmd_col, 7);
        tick();
        tick();
        bus.dram_data_in = 1'b1;
        tick();
        bus.dram_data_in = 1'b0;
        chk("s6_rsp_c6",     bus.rsp_valid, 1);
        tick();

        // miss read row9 col2 with row5 open, then back-to-back hit read
        issue(1'b0, 7'd9, 3'd2, 1'b0);
        tick();
        idle_req();
        chk("s3_pre_c1",     bus.cmd,      3);
        chk("s3_prerow_c1",  bus.cmd_row,  0);
        tick();
        chk("s3_nop_c2",     bus.cmd,      0);
        chk("s3_rowopen_c2", bus.row_open, 0);
        tick();
        chk("s3_act_c3",     bus.cmd,      1);
        chk("s3_actrow_c3",  bus.cmd_row,  9);
        tick();
        chk("s3_nop_c4",     bus.cmd,      0);
        tick();
        chk("s3_rd_c5",      bus.cmd,      2);
        chk("s3_col_c5",     bus.cmd_col,  2);
        tick();
        tick();
        bus.dram_data_in = 1'b1;
        tick();
        bus.dram_data_in = 1'b0;
        chk("s3_rsp_c8",     bus.rsp_valid, 1);
        chk("s3_rdata_c8",   bus.rsp_data,  1);
        chk("s3_openrow_c8", bus.open_row,  9);
        chk("s3_ready_c8",   bus.req_ready, 1);
        issue(1'b0, 7'd9, 3'd4, 1'b0);
        tick();
        idle_req();
        chk("b2b_rd_c9",     bus.cmd,       2);
        chk("b2b_col_c9",    bus.cmd_col,   4);
        chk("b2b_rspoff_c9", bus.rsp_valid, 0);
        tick();
        tick();
        tick();
        chk("b2b_rsp_c12",   bus.rsp_valid, 1);
        chk("b2b_rdata_c12", bus.rsp_data,  0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
